// File: rtl/router_arb_pkg.sv
// Shared definitions for the per-output-port arbiter: register map,
// CTRL bit positions and the arbitration FSM state type.
package router_arb_pkg;

  localparam int unsigned ADDR_CTRL       = 0;
  localparam int unsigned ADDR_MASK       = 1;
  localparam int unsigned ADDR_STATUS     = 2;
  localparam int unsigned ADDR_CNT_BASE   = 4;

  localparam int unsigned CTRL_EN_BIT     = 0;
  localparam int unsigned CTRL_MODE_BIT   = 1;

  localparam int unsigned STATUS_ERR_BIT  = 0;
  localparam int unsigned STATUS_IDX_LSB  = 4;
  localparam int unsigned STATUS_BUSY_BIT = 7;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational winner selection over a request vector.
// Round-robin searches upward from i_ptr+1 with wrap; fixed mode picks the
// lowest set index. Returns a one-hot grant, its index and an any-valid flag.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_ptr,
  input  logic               i_fixed,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IW-1:0]      o_idx,
  output logic               o_any
);

  // Priority search; the first hit found in search order wins.
  always_comb begin
    int unsigned w_cand;
    o_gnt  = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    w_cand = 0;
    if (i_fixed) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!o_any && i_req[i]) begin
          o_any    = 1'b1;
          o_idx    = IW'(i);
          o_gnt[i] = 1'b1;
        end
      end
    end else begin
      for (int unsigned off = 1; off <= NUM_REQ; off++) begin
        w_cand = {{(32-IW){1'b0}}, i_ptr} + off;
        if (w_cand >= NUM_REQ) begin
          w_cand = w_cand - NUM_REQ;
        end
        if (!o_any && i_req[w_cand]) begin
          o_any         = 1'b1;
          o_idx         = IW'(w_cand);
          o_gnt[w_cand] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/router_port_arbiter.sv
// Per-output-port scheduler: shares one destination port among NUM_REQ
// sources with packet-level grant locking, a stall timeout with a sticky
// error flag, and a small configuration register file.
module router_port_arbiter
  import router_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DW      = 8,
  parameter int unsigned AW      = 4,
  parameter int unsigned TIMEOUT = 16,
  localparam int unsigned IW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] eop,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      gnt_idx,
  output logic               busy,
  output logic               err,
  input  logic               wr,
  input  logic               rd,
  input  logic [AW-1:0]      addr,
  input  logic [DW-1:0]      wdata,
  output logic [DW-1:0]      rdata
);

  localparam int unsigned SW = $clog2(TIMEOUT + 1);

  arb_state_t         r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [IW-1:0]      r_gnt_idx, w_idx_nxt;
  logic [IW-1:0]      r_rr_ptr, w_rr_nxt;
  logic [SW-1:0]      r_stall, w_stall_nxt;
  logic               w_err_set;
  logic               w_cnt_inc;

  logic [1:0]         r_ctrl;
  logic [NUM_REQ-1:0] r_mask;
  logic [7:0]         r_cnt [NUM_REQ];
  logic               r_err;
  logic [DW-1:0]      r_rdata, w_rd_val;

  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_pick_gnt;
  logic [IW-1:0]      w_pick_idx;
  logic [IW-1:0]      w_pick_ptr;
  logic               w_pick_any;
  logic               w_busy;
  logic               w_req_g;
  logic               w_eop_g;
  logic               w_cfg_wr;
  logic               w_unused_ok;

  assign w_busy   = (r_state == ARB_BUSY);
  assign w_req_g  = req[r_gnt_idx];
  assign w_eop_g  = eop[r_gnt_idx];
  assign w_elig   = req & r_mask & {NUM_REQ{r_ctrl[CTRL_EN_BIT]}};
  assign w_cfg_wr = wr;
  assign w_unused_ok = ^wdata[DW-1:NUM_REQ];

  // While busy the current owner is the pointer, so it gets lowest priority
  // in the back-to-back re-arbitration on its eop beat.
  assign w_pick_ptr = w_busy ? r_gnt_idx : r_rr_ptr;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .i_req   (w_elig),
    .i_ptr   (w_pick_ptr),
    .i_fixed (r_ctrl[CTRL_MODE_BIT]),
    .o_gnt   (w_pick_gnt),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, grant, pointer, stall and event decode.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_idx_nxt   = r_gnt_idx;
    w_rr_nxt    = r_rr_ptr;
    w_stall_nxt = r_stall;
    w_err_set   = 1'b0;
    w_cnt_inc   = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        w_stall_nxt = '0;
        if (w_pick_any) begin
          w_state_nxt = ARB_BUSY;
          w_gnt_nxt   = w_pick_gnt;
          w_idx_nxt   = w_pick_idx;
        end
      end
      ARB_BUSY: begin
        if (w_req_g) begin
          w_stall_nxt = '0;
          if (w_eop_g) begin
            w_cnt_inc = 1'b1;
            w_rr_nxt  = r_gnt_idx;
            if (w_pick_any) begin
              w_gnt_nxt = w_pick_gnt;
              w_idx_nxt = w_pick_idx;
            end else begin
              w_state_nxt = ARB_IDLE;
              w_gnt_nxt   = '0;
              w_idx_nxt   = '0;
            end
          end
        end else if (r_stall == SW'(TIMEOUT - 1)) begin
          w_err_set   = 1'b1;
          w_state_nxt = ARB_IDLE;
          w_gnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_rr_nxt    = r_gnt_idx;
          w_stall_nxt = '0;
        end else begin
          w_stall_nxt = r_stall + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ARB_IDLE;
        w_gnt_nxt   = '0;
        w_idx_nxt   = '0;
        w_stall_nxt = '0;
      end
    endcase
  end

  // Grant, pointer and stall registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_gnt     <= '0;
      r_gnt_idx <= '0;
      r_rr_ptr  <= IW'(NUM_REQ - 1);
      r_stall   <= '0;
    end else begin
      r_gnt     <= w_gnt_nxt;
      r_gnt_idx <= w_idx_nxt;
      r_rr_ptr  <= w_rr_nxt;
      r_stall   <= w_stall_nxt;
    end
  end

  // Writable configuration; the timeout set takes priority over W1C.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ctrl <= 2'b01;
      r_mask <= '1;
      r_err  <= 1'b0;
    end else begin
      if (w_cfg_wr && (addr == AW'(ADDR_CTRL))) begin
        r_ctrl <= wdata[1:0];
      end
      if (w_cfg_wr && (addr == AW'(ADDR_MASK))) begin
        r_mask <= wdata[NUM_REQ-1:0];
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end else if (w_cfg_wr && (addr == AW'(ADDR_STATUS)) && wdata[STATUS_ERR_BIT]) begin
        r_err <= 1'b0;
      end
    end
  end

  // Completed-packet counters, 8-bit wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (w_cnt_inc && (r_gnt_idx == IW'(i))) begin
          r_cnt[i] <= r_cnt[i] + 8'd1;
        end
      end
    end
  end

  // Read-data mux; unmapped addresses read as zero.
  always_comb begin
    w_rd_val = '0;
    if (addr == AW'(ADDR_CTRL)) begin
      w_rd_val[1:0] = r_ctrl;
    end else if (addr == AW'(ADDR_MASK)) begin
      w_rd_val[NUM_REQ-1:0] = r_mask;
    end else if (addr == AW'(ADDR_STATUS)) begin
      w_rd_val[STATUS_ERR_BIT]              = r_err;
      w_rd_val[STATUS_IDX_LSB +: IW]        = r_gnt_idx;
      w_rd_val[STATUS_BUSY_BIT]             = w_busy;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (addr == AW'(ADDR_CNT_BASE + i)) begin
          w_rd_val[7:0] = r_cnt[i];
        end
      end
    end
  end

  // Registered read data, held between reads; a concurrent write suppresses the read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdata <= '0;
    end else if (rd && !wr) begin
      r_rdata <= w_rd_val;
    end
  end

  assign gnt     = r_gnt;
  assign gnt_idx = r_gnt_idx;
  assign busy    = w_busy;
  assign err     = r_err;
  assign rdata   = r_rdata;

endmodule

// File: doc/router_port_arbiter.md
Name: router_port_arbiter

Overview:
- Per-output-port scheduler for the 4x4 router. Shares one destination port (da_n/da_n_valid) among NUM_REQ source requesters.
- Round-robin or fixed-priority arbitration with packet-level grant locking.
- Stall timeout with sticky error flag.
- Small register file on the router's wr/rd/addr/wdata/rdata configuration bus. One instance sits in front of each output mux.

Parameters:
NUM_REQ, 4, number of requesting source ports (index width IW = clog2(NUM_REQ))
DW, 8, configuration data width
AW, 4, configuration address width
TIMEOUT, 16, cycles a locked requester may hold req low before abort

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
req  input  NUM_REQ  requester i has a packet beat pending
eop  input  NUM_REQ  qualifies req[i]: current beat is last of packet
gnt  output  NUM_REQ  one-hot grant, registered
gnt_idx  output  IW  index of granted requester, valid when busy=1
busy  output  1  a packet is locked to the port
err  output  1  sticky timeout error
wr  input  1  config write strobe
rd  input  1  config read strobe
addr  input  AW  config register address
wdata  input  DW  config write data
rdata  output  DW  config read data, registered

Behaviour:
- Reset (reset=0, async): gnt=0, gnt_idx=0, busy=0, err=0, rdata=0, rr pointer=NUM_REQ-1, CTRL=0x01 (enabled, RR), MASK=all ones, packet counters=0.
- Beat transfer: occurs on a cycle where gnt[i]=1 and req[i]=1. If eop[i]=1 on that cycle, the packet ends.
- FSM IDLE:
  - Eligible set E = req & MASK & {NUM_REQ{CTRL.en}}.
  - If E is non-zero, pick winner W and go to BUSY. gnt[W]=1, gnt_idx=W and busy=1 on the next edge. Latency is 1 cycle from req to gnt.
  - RR mode (CTRL.mode=0): W is the first set bit of E searching from rr_ptr+1 upward with wrap.
  - Fixed mode (CTRL.mode=1): W is the lowest set index.
- FSM BUSY:
  - Grant is locked. Changes to MASK or en do not revoke it.
  - On the eop beat: cnt[g] increments (8-bit wrap) and rr_ptr<=g. Arbitration runs the same cycle over E excluding nothing; g has the lowest RR priority. If E is non-zero, gnt moves to the new winner on the next edge (back-to-back, no idle cycle). Otherwise go to IDLE and gnt=0.
  - Stall counter: clears on every beat; increments while req[g]=0.
  - When the stall counter reaches TIMEOUT-1 with req[g] still 0: abort. err<=1, gnt=0, go to IDLE, rr_ptr<=g. cnt is not incremented.
- Register map (byte addresses):
  - 0x0 CTRL: bit0 en, bit1 mode.
  - 0x1 MASK: bits[NUM_REQ-1:0].
  - 0x2 STATUS (RO except err): bit0 err (write 1 to clear), bits[5:4] gnt_idx, bit7 busy.
  - 0x4+i CNT[i]: RO.
  - Unmapped reads return 0. Unmapped writes are ignored.
- Config timing:
  - A write takes effect for the arbitration decision on the following cycle.
  - rd: rdata is updated on the next edge and held until the next rd.
  - wr and rd asserted together: write wins, rdata is unchanged.
- err set and W1C in the same cycle: set wins.
- CNT read on the same cycle as an increment returns the pre-increment value.
- Reset mid-packet: the grant drops immediately (async). The requester must restart the packet.

Decomposition:
- Package router_arb_pkg: register address constants (ADDR_CTRL, ADDR_MASK, ADDR_STATUS, ADDR_CNT_BASE), CTRL bit positions, typedef enum {ARB_IDLE, ARB_BUSY} arb_state_t.
- Sub-module rr_pick: combinational, takes a request vector, a pointer and a mode, and returns a one-hot winner plus index. Reused by the crossbar-level scheduler later.

Test Plan:
- Reset, then read 0x0/0x1/0x2 → 0x01 / 0x0F / 0x00. All gnt=0.
- RR fairness: req=4'b1111 with eop every beat for 8 beats → gnt_idx sequence 0,1,2,3,0,1,2,3. CNT[0..3]=2 each.
- Packet lock: req[2] 3-beat packet (eop on beat 3) with req[0] asserted from cycle 1 → gnt stays on 2 for 3 beats, then moves to 0 on the very next cycle (no idle).
- Fixed mode + mask: write CTRL=0x03, MASK=0x0C; req=4'b1111 → only gnt[2] repeatedly. req[0],req[1] never granted.
- Timeout: grant to 1, drop req[1] without eop for 16 cycles → gnt=0 and err=1 on cycle 16. STATUS reads 0x01. Write 0x2=0x01 → err=0.
- Async reset asserted mid-packet with gnt[3]=1 → gnt=0 and busy=0 without a clock edge. After release, CNT=0 and the first grant goes to lowest requester index.
